cell_sweep_ctrl: RTL and testbench
==================================

// Module: cell_sweep_ctrl
// PURPOSE
//  Clocked sequencer for exhaustive truth-table checks of a combinational standard cell (e.g. AOI21_X2).
//  - Drives every input vector 0..2**N_IN-1 in ascending order.
//  - Holds each vector for a settle window, then samples the cell output and compares it to EXP_TT.
//  - Records the observed truth table and counts mismatches.
//  - Sits between the bench top and the cell instance.
// PARAMETERS
//  N_IN    3             number of cell inputs; vec_out MSB maps to the first cell pin (A,B1,B2 order)
//  SETTLE  10            cycles each vector is held before sampling; legal range 1..255
//  GAP     5             idle cycles between sample and next vector, vec_out held; 0 = back-to-back
//  EXP_TT  8'b0000_0111  expected output, bit i = response to vector i (default = AOI21: ZN=!(A|(B1&B2)))
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          asynchronous, active-high reset
//  start         in   1          one-cycle pulse that begins a sweep
//  abort         in   1          one-cycle pulse that cancels a sweep
//  dut_out       in   1          cell output (ZN)
//  vec_out       out  N_IN       cell input vector
//  sample_valid  out  1          one-cycle pulse: sample_idx/sample_bit are valid
//  sample_idx    out  N_IN       index of the vector just sampled
//  sample_bit    out  1          dut_out value captured for sample_idx
//  busy          out  1          sweep in progress
//  done          out  1          sweep complete; held until next start, abort or rst
//  pass          out  1          done & (err_cnt==0)
//  err_cnt       out  N_IN+1     mismatch count; max value 2**N_IN, never wraps
//  obs_tt        out  2**N_IN    observed truth table
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; every output = 0; obs_tt=0; err_cnt=0.
//  - FSM states: IDLE, DRIVE, GAP, DONE.
//  - IDLE/DONE + start: clear obs_tt, err_cnt, done; vec_out<=0; go to DRIVE. busy=1 from the next cycle.
//  - DRIVE: lasts exactly SETTLE cycles with vec_out stable.
//    - On the edge ending the last DRIVE cycle: obs_tt[idx]<=dut_out, sample_bit<=dut_out, sample_idx<=idx,
//      sample_valid<=1 for 1 cycle.
//    - Mismatch (dut_out !== EXP_TT[idx]; X/Z counts as mismatch): err_cnt+1 on the same edge.
//  - Exit from DRIVE:
//    - idx==2**N_IN-1: go to DONE; done=1 and busy=0 in the same cycle as the final sample_valid.
//    - otherwise: go to GAP, or straight to DRIVE if GAP==0.
//  - GAP: lasts GAP cycles with vec_out unchanged. On exit: vec_out<=idx+1, enter DRIVE.
//  - Sweep latency: start edge to done = 2**N_IN*SETTLE + (2**N_IN-1)*GAP cycles (defaults: 115).
//  - idx never wraps inside a sweep. A new sweep always restarts at vector 0.
//  - start while busy: ignored.
//  - abort in DRIVE/GAP: next cycle IDLE; vec_out=0; busy=0; done=0. obs_tt/err_cnt keep partial values.
//  - abort in IDLE/DONE: clears done only.
//  - start and abort in the same cycle: abort wins, start is dropped.
//  - rst mid-sweep: immediate IDLE, all outputs 0. No sample is taken.
// CONFIGURATION
//  SWEEP_STOP_ON_ERR_EN
//    - Defined: the first mismatch ends the sweep on the same edge. Go to DONE with done=1, pass=0, err_cnt=1.
//      vec_out and sample_idx hold the failing vector. obs_tt bits above it stay 0.
//    - Undefined: all 2**N_IN vectors are always applied. err_cnt is the total mismatch count.
// TESTING
//  - Golden AOI21 model, defaults, start:
//    vec_out steps 0..7 every 15 cycles; done at cycle 115; obs_tt=8'h07; err_cnt=0; pass=1.
//  - Model with ZN stuck-at-0:
//    err_cnt=3, obs_tt=8'h00, pass=0. With SWEEP_STOP_ON_ERR_EN: done after 10 cycles, sample_idx=0, err_cnt=1.
//  - abort pulsed while vec_out=3:
//    next cycle busy=0, done=0, vec_out=0. obs_tt[2:0]=3'b111 retained. A following start clears it and sweeps from 0.
//  - start pulsed again at cycles 20 and 50 of a sweep:
//    no effect. Same 115-cycle timing and results as the first scenario.
//  - rst asserted mid-DRIVE, between clock edges:
//    outputs 0 immediately, with no clock. After release, start gives a full clean sweep.
//  - SETTLE=1, GAP=0:
//    vec_out changes every cycle; 8 sample_valid pulses on consecutive cycles; done at cycle 8.

Source files
------------

// File: rtl/cell_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a combinational cell: drives every input vector,
// samples and scores the cell output. Optional build macro: SWEEP_STOP_ON_ERR_EN.
module cell_sweep_ctrl #(
  parameter int                  N_IN   = 3,
  parameter int                  SETTLE = 10,
  parameter int                  GAP    = 5,
  parameter logic [2**N_IN-1:0]  EXP_TT = 8'b0000_0111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_out,
  output logic [N_IN-1:0]     vec_out,
  output logic                sample_valid,
  output logic [N_IN-1:0]     sample_idx,
  output logic                sample_bit,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
  output logic [2**N_IN-1:0]  obs_tt
);

  localparam int NVEC    = 2**N_IN;
  localparam int CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   GAP_LAST    = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NVEC - 1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);
  localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(NVEC);

`ifdef SWEEP_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [N_IN-1:0]  idx_reg, idx_next;
  logic [N_IN-1:0]  vec_reg, vec_next;
  logic [NVEC-1:0]  obs_reg, obs_next;
  logic [N_IN:0]    err_reg, err_next;
  logic             sv_reg, sv_next;
  logic [N_IN-1:0]  sidx_reg, sidx_next;
  logic             sbit_reg, sbit_next;
  logic             mismatch;

  // Case-inequality so an X/Z from the cell is scored as a mismatch.
  assign mismatch = (dut_out !== EXP_TT[idx_reg]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      vec_reg   <= '0;
      obs_reg   <= '0;
      err_reg   <= '0;
      sv_reg    <= 1'b0;
      sidx_reg  <= '0;
      sbit_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      vec_reg   <= vec_next;
      obs_reg   <= obs_next;
      err_reg   <= err_next;
      sv_reg    <= sv_next;
      sidx_reg  <= sidx_next;
      sbit_reg  <= sbit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    vec_next   = vec_reg;
    obs_next   = obs_reg;
    err_next   = err_reg;
    sv_next    = 1'b0;
    sidx_next  = sidx_reg;
    sbit_next  = sbit_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        // abort has priority; a start in the same cycle is dropped
        if (abort) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next = S_DRIVE;
          cnt_next   = '0;
          idx_next   = '0;
          vec_next   = '0;
          obs_next   = '0;
          err_next   = '0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          vec_next   = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          sv_next           = 1'b1;
          sidx_next         = idx_reg;
          sbit_next         = dut_out;
          obs_next[idx_reg] = dut_out;
          if (mismatch && (err_reg != ERR_MAX))
            err_next = err_reg + ERR_ONE;
          cnt_next = '0;
          if ((idx_reg == IDX_LAST) || (STOP_ON_ERR && mismatch)) begin
            state_next = S_DONE;
          end else if (GAP == 0) begin
            idx_next = idx_reg + IDX_ONE;
            vec_next = idx_reg + IDX_ONE;
          end else begin
            state_next = S_GAP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          vec_next   = '0;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = S_DRIVE;
          cnt_next   = '0;
          idx_next   = idx_reg + IDX_ONE;
          vec_next   = idx_reg + IDX_ONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign vec_out      = vec_reg;
  assign sample_valid = sv_reg;
  assign sample_idx   = sidx_reg;
  assign sample_bit   = sbit_reg;
  assign busy         = (state_reg == S_DRIVE) || (state_reg == S_GAP);
  assign done         = (state_reg == S_DONE);
  assign pass         = done && (err_reg == '0);
  assign err_cnt      = err_reg;
  assign obs_tt       = obs_reg;

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// Bench for cell_sweep_ctrl: default instance plus a SETTLE=1/GAP=0 instance, each driving
// a table-defined cell; results are scored against a sweep-level reference model.
module tb_cell_sweep_ctrl;

  localparam logic [7:0] EXP = 8'b0000_0111;
`ifdef SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;
  logic [7:0] tt_a = EXP;
  logic [7:0] tt_b = EXP;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [2:0] vec_a, sidx_a, vec_b, sidx_b;
  logic       sv_a, sbit_a, busy_a, done_a, pass_a;
  logic       sv_b, sbit_b, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
  logic [7:0] obs_a, obs_b;
  logic       start_a, abort_a, start_b, abort_b, dout_a, dout_b;

  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  assign start_b = start & sel;
  assign abort_b = abort & sel;
  assign dout_a  = tt_a[vec_a];
  assign dout_b  = tt_b[vec_b];

  cell_sweep_ctrl #(.N_IN(3), .SETTLE(10), .GAP(5), .EXP_TT(EXP)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_out(dout_a),
    .vec_out(vec_a), .sample_valid(sv_a), .sample_idx(sidx_a), .sample_bit(sbit_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .obs_tt(obs_a));

  cell_sweep_ctrl #(.N_IN(3), .SETTLE(1), .GAP(0), .EXP_TT(EXP)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_out(dout_b),
    .vec_out(vec_b), .sample_valid(sv_b), .sample_idx(sidx_b), .sample_bit(sbit_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .obs_tt(obs_b));

  // View of whichever instance the current step exercises
  logic [2:0] c_vec, c_sidx;
  logic       c_sv, c_sbit, c_busy, c_done, c_pass;
  logic [3:0] c_err;
  logic [7:0] c_obs;
  assign c_vec  = sel ? vec_b  : vec_a;
  assign c_sidx = sel ? sidx_b : sidx_a;
  assign c_sv   = sel ? sv_b   : sv_a;
  assign c_sbit = sel ? sbit_b : sbit_a;
  assign c_busy = sel ? busy_b : busy_a;
  assign c_done = sel ? done_b : done_a;
  assign c_pass = sel ? pass_b : pass_a;
  assign c_err  = sel ? err_b  : err_a;
  assign c_obs  = sel ? obs_b  : obs_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Sweep outcome from the cell's truth table: vectors visited in order, one per SETTLE+GAP slot.
  function automatic void model(input logic [7:0] tt, input int s, input int g,
                                output int lat, output logic [7:0] obs,
                                output int err, output int last);
    err = 0; obs = '0; lat = 0; last = 0;
    for (int i = 0; i < 8; i++) begin
      obs[i] = tt[i];
      lat    = i * (s + g) + s;
      last   = i;
      if (tt[i] !== EXP[i]) begin
        err++;
        if (STOP) break;
      end
    end
  endfunction

  task automatic sweep(input logic use_b, input logic [7:0] tt, input logic poke, input string tag);
    int s, g, lat, err, last, cyc, bad_vec, bad_smp, idx;
    logic [7:0] obs;
    s = use_b ? 1 : 10;
    g = use_b ? 0 : 5;
    sel = use_b;
    if (use_b) tt_b = tt; else tt_a = tt;
    model(tt, s, g, lat, obs, err, last);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; bad_vec = 0; bad_smp = 0;
    while (!c_done && cyc < 400) begin
      if (c_vec !== 3'(cyc / (s + g)) || c_busy !== 1'b1) bad_vec++;
      if (cyc >= s && (cyc - s) % (s + g) == 0) begin
        idx = (cyc - s) / (s + g);
        if (!(c_sv === 1'b1 && c_sidx === 3'(idx) && c_sbit === tt[idx])) bad_smp++;
      end else if (c_sv !== 1'b0) begin
        bad_smp++;
      end
      start = poke && (cyc == 20 || cyc == 50);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_vec_steps"}, bad_vec, 0);
    check({tag, "_samples"}, bad_smp, 0);
    check({tag, "_final"}, {c_vec, c_sidx, c_sv, c_sbit, c_busy},
          {3'(last), 3'(last), 1'b1, tt[last], 1'b0});
    check({tag, "_obs"}, c_obs, obs);
    check({tag, "_err"}, c_err, err);
    check({tag, "_pass"}, c_pass, (err == 0));
    @(negedge clk);
    check({tag, "_hold"}, {c_done, c_sv}, 2'b10);
    $display("sweep %s tt=%02h obs=%02h err=%0d lat=%0d", tag, tt, c_obs, c_err, cyc);
  endtask

  initial begin
    int cyc;
    logic [7:0] obs_keep;
    repeat (2) @(negedge clk);
    check("rst_zero_a", {vec_a, sv_a, sidx_a, sbit_a, busy_a, done_a, pass_a, err_a, obs_a}, 0);
    check("rst_zero_b", {vec_b, sv_b, sidx_b, sbit_b, busy_b, done_b, pass_b, err_b, obs_b}, 0);
    rst = 1'b0;

    sweep(1'b0, EXP, 1'b0, "a_golden");
    sweep(1'b0, 8'h00, 1'b0, "a_stuck0");
    sweep(1'b0, EXP, 1'b1, "a_restart_ignored");

    // abort in DONE clears done only
    obs_keep = obs_a;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("abort_done", {done_a, busy_a, obs_a}, {1'b0, 1'b0, obs_keep});

    // abort mid-sweep while vector 3 is applied
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 0;
    while (vec_a !== 3'd3 && cyc < 200) begin @(negedge clk); cyc++; end
    check("abort_reach_v3", vec_a, 3);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("abort_mid", {busy_a, done_a, vec_a}, 0);
    check("abort_partial", obs_a, 8'h07);
    sweep(1'b0, EXP, 1'b0, "a_after_abort");

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_same", {busy_a, done_a}, 0);

    // asynchronous reset between edges during DRIVE
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (32) @(negedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst", {vec_a, sv_a, sidx_a, sbit_a, busy_a, done_a, pass_a, err_a, obs_a}, 0);
    @(negedge clk); rst = 1'b0;
    sweep(1'b0, EXP, 1'b0, "a_after_rst");

    sweep(1'b1, EXP, 1'b0, "b_golden");
    sweep(1'b1, 8'h00, 1'b0, "b_stuck0");
    for (int k = 0; k < 3; k++) begin
      sweep(1'b0, 8'($urandom), 1'b0, "a_random");
      sweep(1'b1, 8'($urandom), 1'b0, "b_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
